// File: rtl/wb_burst_master.sv
// Wishbone burst master: issues incrementing write bursts of a seeded data pattern,
// or read bursts that check the returned data against that pattern.
module wb_burst_master #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned BW     = 4,
  parameter int unsigned TMO    = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [31:0]       cmd_seed,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [31:0]       wb_dat_o,
  output logic [BW-1:0]     wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [31:0]       wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       err_cnt
);

  localparam int unsigned TW = $clog2(TMO + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        len_q, len_d;
  logic [31:0]       seed_q, seed_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       err_q, err_d;
  logic              tmo_q, tmo_d;

  logic        in_burst;
  logic        last_beat;
  logic [31:0] exp_data;

  assign in_burst  = (state_q == StWrite) || (state_q == StRead);
  assign last_beat = (beat_q == len_q);
  assign exp_data  = seed_q + {24'd0, beat_q};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    len_d   = len_q;
    seed_d  = seed_q;
    timer_d = timer_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          seed_d  = cmd_seed;
          len_d   = cmd_len;
          addr_d  = cmd_addr & ~APP_AW'(3);
          beat_d  = 8'd0;
          timer_d = '0;
          err_d   = 16'd0;
          tmo_d   = 1'b0;
          state_d = cmd_write ? StWrite : StRead;
        end
      end
      StWrite, StRead: begin
        if (wb_ack_i) begin
          timer_d = '0;
          if ((state_q == StRead) && (wb_dat_i != exp_data) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
          if (last_beat) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_q + APP_AW'(4);
          end
        end else begin
          timer_d = timer_q + TW'(1);
          // TMO consecutive ack-less cycles abort the burst, keeping progress and errors
          if (timer_q == TW'(TMO - 1)) begin
            tmo_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      beat_q  <= 8'd0;
      len_q   <= 8'd0;
      seed_q  <= 32'd0;
      timer_q <= '0;
      err_q   <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Bus outputs are decoded from state so reset drops the cycle without a clock edge
  assign cmd_ready = (state_q == StIdle);
  assign wb_cyc_o  = in_burst;
  assign wb_stb_o  = in_burst;
  assign wb_we_o   = (state_q == StWrite);
  assign wb_addr_o = in_burst ? addr_q : '0;
  assign wb_dat_o  = (state_q == StWrite) ? exp_data : 32'd0;
  assign wb_sel_o  = in_burst ? {BW{1'b1}} : '0;
  assign wb_cti_o  = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign timeout   = tmo_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomised bench for wb_burst_master: a memory-backed slave plus a beat-level model
// of the expected bus activity, error count, timeout and completion latency.
module tb_wb_burst_master;

  localparam int unsigned AW  = 26;
  localparam int unsigned BW  = 4;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [31:0]   cmd_seed;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_dat_o;
  logic [BW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [31:0]   wb_dat_i;
  logic          busy, done, timeout;
  logic [15:0]   err_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [AW-1:0]];

  wb_burst_master #(.APP_AW(AW), .BW(BW), .TMO(TMO)) u_dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_seed  (cmd_seed),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_addr_o (wb_addr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_cti_o  (wb_cti_o),
    .wb_ack_i  (wb_ack_i),
    .wb_dat_i  (wb_dat_i),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check_eq({tag, ".cyc"}, wb_cyc_o, 1'b0);
    check_eq({tag, ".stb"}, wb_stb_o, 1'b0);
    check_eq({tag, ".we"}, wb_we_o, 1'b0);
    check_eq({tag, ".addr"}, wb_addr_o, '0);
    check_eq({tag, ".dat"}, wb_dat_o, 32'd0);
    check_eq({tag, ".sel"}, wb_sel_o, '0);
    check_eq({tag, ".cti"}, wb_cti_o, 3'b000);
  endtask

  // One command from acceptance to the cycle after done; exp_lat < 0 skips the latency check
  task automatic run_burst(input logic wr, input logic [AW-1:0] addr, input int len,
                           input logic [31:0] seed, input int ack_pct, input int corrupt_beat,
                           input bit hold_valid, input int exp_lat);
    int n, stall, cyc;
    bit fin, tmo;
    logic [15:0] errs;
    logic [AW-1:0] base, a;
    logic [31:0] rdata, pat;
    base = addr & ~AW'(3);
    @(negedge clk);
    check_eq("accept.ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    cmd_seed  = seed;
    @(negedge clk);
    cyc = 1;
    if (!hold_valid) cmd_valid = 1'b0;
    n = 0; stall = 0; errs = 16'd0; fin = 1'b0; tmo = 1'b0;
    while (!fin) begin
      a   = AW'(base + AW'(n * 4));
      pat = seed + 32'(n);
      check_eq("beat.cyc", wb_cyc_o, 1'b1);
      check_eq("beat.stb", wb_stb_o, 1'b1);
      check_eq("beat.we", wb_we_o, wr);
      check_eq("beat.addr", wb_addr_o, a);
      check_eq("beat.dat", wb_dat_o, wr ? pat : 32'd0);
      check_eq("beat.sel", wb_sel_o, {BW{1'b1}});
      check_eq("beat.cti", wb_cti_o, (n == len) ? 3'b111 : 3'b010);
      check_eq("beat.busy", busy, 1'b1);
      check_eq("beat.done", done, 1'b0);
      check_eq("beat.ready", cmd_ready, 1'b0);
      check_eq("beat.tmo", timeout, 1'b0);
      check_eq("beat.err", err_cnt, errs);
      if (hold_valid) begin
        cmd_write = ~wr;
        cmd_addr  = AW'($urandom);
        cmd_len   = 8'($urandom);
        cmd_seed  = $urandom;
      end
      wb_ack_i = ($urandom_range(99) < ack_pct);
      if (wb_ack_i) begin
        rdata = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
        if (n == corrupt_beat) rdata = rdata ^ 32'h0000_0100;
        wb_dat_i = rdata;
        if (wr) mem[a] = wb_dat_o;
        else if (rdata != pat && errs != 16'hFFFF) errs = errs + 16'd1;
        stall = 0;
        if (n == len) fin = 1'b1;
        else n++;
      end else begin
        wb_dat_i = $urandom;
        stall++;
        if (stall == TMO) begin
          fin = 1'b1;
          tmo = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    wb_ack_i  = 1'b0;
    cmd_valid = 1'b0;
    check_eq("done.pulse", done, 1'b1);
    check_eq("done.busy", busy, 1'b1);
    check_eq("done.ready", cmd_ready, 1'b0);
    check_eq("done.tmo", timeout, tmo);
    check_eq("done.err", err_cnt, errs);
    check_idle_bus("done");
    if (exp_lat >= 0) check_eq("done.latency", cyc, exp_lat);
    @(negedge clk);
    check_eq("idle.done", done, 1'b0);
    check_eq("idle.busy", busy, 1'b0);
    check_eq("idle.ready", cmd_ready, 1'b1);
    check_eq("idle.tmo", timeout, tmo);
    check_eq("idle.err", err_cnt, errs);
    check_idle_bus("idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    int rl;
    logic [31:0] rs;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
    cmd_seed = 32'd0; wb_ack_i = 1'b0; wb_dat_i = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst.ready", cmd_ready, 1'b1);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    check_eq("rst.tmo", timeout, 1'b0);
    check_eq("rst.err", err_cnt, 16'd0);
    check_idle_bus("rst");
    rst = 1'b0;

    // Stray ack while idle must not start anything
    @(negedge clk);
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    check_eq("idleack.busy", busy, 1'b0);
    check_eq("idleack.cyc", wb_cyc_o, 1'b0);
    check_eq("idleack.done", done, 1'b0);

    run_burst(1'b1, 26'h100, 3, 32'hA5A5_0000, 100, -1, 1'b0, 5);
    run_burst(1'b0, 26'h100, 3, 32'hA5A5_0000, 100, -1, 1'b0, 5);
    run_burst(1'b0, 26'h100, 3, 32'hA5A5_0000, 100, 2, 1'b0, 5);
    check_eq("corrupt.err", err_cnt, 16'd1);
    run_burst(1'b1, 26'h200, 0, 32'h1234_5678, 100, -1, 1'b0, 2);
    run_burst(1'b1, 26'h3FF_FFFC, 1, 32'hCAFE_0000, 100, -1, 1'b0, 3);
    check_eq("wrap.mem0", mem.exists(26'h0) ? mem[26'h0] : 32'h0, 32'hCAFE_0001);
    run_burst(1'b0, 26'h3FF_FFFC, 1, 32'hCAFE_0000, 70, -1, 1'b0, -1);
    run_burst(1'b1, 26'h400, 6, 32'h0BAD_F00D, 80, -1, 1'b1, -1);
    run_burst(1'b0, 26'h100, 5, 32'hA5A5_0000, 0, -1, 1'b0, TMO + 1);
    repeat (3) @(negedge clk);
    check_eq("tmo.sticky", timeout, 1'b1);
    check_eq("tmo.stillidle", busy, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = AW'($urandom);
      rl = int'($urandom_range(15));
      rs = $urandom;
      run_burst(1'b1, ra, rl, rs, int'($urandom_range(100, 60)), -1, 1'b0, -1);
      run_burst(1'b0, ra, rl, rs, int'($urandom_range(100, 60)),
                ($urandom_range(2) == 0) ? int'($urandom_range(rl)) : -1, 1'b0, -1);
    end

    // Reset in the middle of a read of unwritten memory (errors already accumulating)
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 26'h2F0_0000; cmd_len = 8'd20;
    cmd_seed = 32'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h5555_5555;
      @(negedge clk);
    end
    check_eq("mid.cyc", wb_cyc_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst.busy", busy, 1'b0);
    check_eq("midrst.ready", cmd_ready, 1'b1);
    check_eq("midrst.err", err_cnt, 16'd0);
    check_idle_bus("midrst");
    wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst.nodone", done, 1'b0);
    end
    rst = 1'b0;
    run_burst(1'b1, 26'h800, 2, 32'h7777_0000, 100, -1, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
